// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
// Register and data widths plus requester count.
package rf_wb_arbiter_pkg;

    localparam int N_REG = 32;
    localparam int N_REQ = 2;

    typedef logic [31:0] data_t;
    typedef logic [4:0]  reg_t;

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter holding the last-grant pointer.
// Grants are combinational; the pointer moves only on a fired transfer.
module rr_arbiter2
    import rf_wb_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] valid,
    input  logic             fire,
    output logic [N_REQ-1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
        if (rst) begin
            grant = '0;
        end
    end

    always_comb begin
        last_d = last_q;
        if (fire) begin
            last_d = grant[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter, registered write port and pending-destination scoreboard.
// WB_BYPASS_EN adds combinational forwarding of the committing write to reads.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wb0_valid,
    input  reg_t             i_wb0_rd,
    input  data_t            i_wb0_data,
    output logic             o_wb0_ready,
    input  logic             i_wb1_valid,
    input  reg_t             i_wb1_rd,
    input  data_t            i_wb1_data,
    output logic             o_wb1_ready,
    input  logic             i_issue_valid,
    input  reg_t             i_issue_rd,
    output logic [N_REG-1:0] o_busy,
`ifdef WB_BYPASS_EN
    input  reg_t             i_Rnum1,
    input  reg_t             i_Rnum2,
    input  data_t            i_Rd1,
    input  data_t            i_Rd2,
    output data_t            o_Rd1,
    output data_t            o_Rd2,
`endif
    output logic             o_Wen,
    output reg_t             o_Wnum,
    output data_t            o_Wd
);

    logic [N_REQ-1:0] req_valid;
    logic [N_REQ-1:0] grant;
    logic             fire;

    logic             wen_q, wen_d;
    reg_t             wnum_q, wnum_d;
    data_t            wd_q, wd_d;
    logic [N_REG-1:0] busy_q, busy_d;

    assign req_valid = {i_wb1_valid, i_wb0_valid};
    assign fire      = |(req_valid & grant);

    rr_arbiter2 u_arb (
        .clk   (i_clk),
        .rst   (i_rst),
        .valid (req_valid),
        .fire  (fire),
        .grant (grant)
    );

    assign o_wb0_ready = grant[0];
    assign o_wb1_ready = grant[1];

    always_comb begin
        wen_d  = 1'b0;
        wnum_d = wnum_q;
        wd_d   = wd_q;
        if (grant[1] && i_wb1_valid) begin
            wen_d  = (i_wb1_rd != '0);
            wnum_d = i_wb1_rd;
            wd_d   = i_wb1_data;
        end else if (grant[0] && i_wb0_valid) begin
            wen_d  = (i_wb0_rd != '0);
            wnum_d = i_wb0_rd;
            wd_d   = i_wb0_data;
        end
    end

    // Set after clear: a fresh issue to the committing register stays pending.
    always_comb begin
        busy_d = busy_q;
        if (wen_q) begin
            busy_d[wnum_q] = 1'b0;
        end
        if (i_issue_valid && (i_issue_rd != '0)) begin
            busy_d[i_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wen_q  <= 1'b0;
            wnum_q <= '0;
            wd_q   <= '0;
            busy_q <= '0;
        end else begin
            wen_q  <= wen_d;
            wnum_q <= wnum_d;
            wd_q   <= wd_d;
            busy_q <= busy_d;
        end
    end

    assign o_Wen  = wen_q;
    assign o_Wnum = wnum_q;
    assign o_Wd   = wd_q;
    assign o_busy = busy_q;

`ifdef WB_BYPASS_EN
    assign o_Rd1 = (wen_q && wnum_q == i_Rnum1 && i_Rnum1 != '0) ? wd_q : i_Rd1;
    assign o_Rd2 = (wen_q && wnum_q == i_Rnum2 && i_Rnum2 != '0) ? wd_q : i_Rd2;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed testbench for rf_wb_arbiter; bypass checks need WB_BYPASS_EN.
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             wb0_valid, wb1_valid;
    reg_t             wb0_rd, wb1_rd;
    data_t            wb0_data, wb1_data;
    logic             wb0_ready, wb1_ready;
    logic             issue_valid;
    reg_t             issue_rd;
    logic [N_REG-1:0] busy;
    logic             wen;
    reg_t             wnum;
    data_t            wd;
`ifdef WB_BYPASS_EN
    reg_t             rnum1, rnum2;
    data_t            rd1_in, rd2_in, rd1_out, rd2_out;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_wb0_valid   (wb0_valid),
        .i_wb0_rd      (wb0_rd),
        .i_wb0_data    (wb0_data),
        .o_wb0_ready   (wb0_ready),
        .i_wb1_valid   (wb1_valid),
        .i_wb1_rd      (wb1_rd),
        .i_wb1_data    (wb1_data),
        .o_wb1_ready   (wb1_ready),
        .i_issue_valid (issue_valid),
        .i_issue_rd    (issue_rd),
        .o_busy        (busy),
`ifdef WB_BYPASS_EN
        .i_Rnum1       (rnum1),
        .i_Rnum2       (rnum2),
        .i_Rd1         (rd1_in),
        .i_Rd2         (rd2_in),
        .o_Rd1         (rd1_out),
        .o_Rd2         (rd2_out),
`endif
        .o_Wen         (wen),
        .o_Wnum        (wnum),
        .o_Wd          (wd)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst         = 1'b1;
        wb0_valid   = 1'b1;
        wb1_valid   = 1'b1;
        wb0_rd      = 5'd1;
        wb1_rd      = 5'd2;
        wb0_data    = 32'h1;
        wb1_data    = 32'h2;
        issue_valid = 1'b1;
        issue_rd    = 5'd4;
`ifdef WB_BYPASS_EN
        rnum1  = '0;
        rnum2  = '0;
        rd1_in = '0;
        rd2_in = '0;
`endif
        tick();
        tick();
        chk("rst_ready0", {31'd0, wb0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, wb1_ready}, 32'd0);
        chk("rst_wen", {31'd0, wen}, 32'd0);
        chk("rst_wnum", {27'd0, wnum}, 32'd0);
        chk("rst_wd", wd, 32'd0);
        chk("rst_busy", busy, 32'd0);

        rst         = 1'b0;
        wb0_valid   = 1'b0;
        wb1_valid   = 1'b0;
        issue_valid = 1'b0;
        tick();
        chk("idle_wen", {31'd0, wen}, 32'd0);
        chk("idle_busy", busy, 32'd0);

        // single write from requester 0
        wb0_valid = 1'b1;
        wb0_rd    = 5'd5;
        wb0_data  = 32'hDEADBEEF;
        #1;
        chk("sw_ready0", {31'd0, wb0_ready}, 32'd1);
        chk("sw_ready1", {31'd0, wb1_ready}, 32'd0);
        tick();
        wb0_valid = 1'b0;
        chk("sw_wen", {31'd0, wen}, 32'd1);
        chk("sw_wnum", {27'd0, wnum}, 32'd5);
        chk("sw_wd", wd, 32'hDEADBEEF);
        tick();
        chk("sw_wen_off", {31'd0, wen}, 32'd0);
        chk("sw_wnum_hold", {27'd0, wnum}, 32'd5);
        chk("sw_wd_hold", wd, 32'hDEADBEEF);

        // reset right after a handshake drops the held write
        wb1_valid = 1'b1;
        wb1_rd    = 5'd9;
        wb1_data  = 32'h99;
        tick();
        wb1_valid = 1'b0;
        rst       = 1'b1;
        tick();
        chk("rdrop_wen", {31'd0, wen}, 32'd0);
        chk("rdrop_wnum", {27'd0, wnum}, 32'd0);
        chk("rdrop_wd", wd, 32'd0);
        rst = 1'b0;

        // contention: pointer back at reset value, so 0 wins first
        wb0_valid = 1'b1;
        wb1_valid = 1'b1;
        wb0_rd    = 5'd1;
        wb1_rd    = 5'd2;
        wb0_data  = 32'hA1;
        wb1_data  = 32'hB2;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ct_ready0_%0d", i), {31'd0, wb0_ready},
                (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("ct_ready1_%0d", i), {31'd0, wb1_ready},
                (i % 2 == 0) ? 32'd0 : 32'd1);
            tick();
            if (i == 3) begin
                wb0_valid = 1'b0;
                wb1_valid = 1'b0;
            end
            chk($sformatf("ct_wnum_%0d", i), {27'd0, wnum},
                (i % 2 == 0) ? 32'd1 : 32'd2);
            chk($sformatf("ct_wd_%0d", i), wd,
                (i % 2 == 0) ? 32'hA1 : 32'hB2);
        end
        tick();
        chk("ct_wen_off", {31'd0, wen}, 32'd0);

        // scoreboard set and clear
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_valid = 1'b0;
        chk("sb_set", busy, 32'h0000_0080);
        wb1_valid = 1'b1;
        wb1_rd    = 5'd7;
        wb1_data  = 32'h77;
        #1;
        chk("sb_ready1", {31'd0, wb1_ready}, 32'd1);
        tick();
        wb1_valid = 1'b0;
        chk("sb_commit_wen", {31'd0, wen}, 32'd1);
        chk("sb_still_busy", busy, 32'h0000_0080);
        tick();
        chk("sb_cleared", busy, 32'd0);

        // re-issue in the commit cycle keeps the bit set
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        wb1_valid   = 1'b1;
        tick();
        wb1_valid   = 1'b0;
        issue_valid = 1'b1;
        chk("sb2_commit_wen", {31'd0, wen}, 32'd1);
        tick();
        issue_valid = 1'b0;
        chk("sb2_set_wins", busy, 32'h0000_0080);

        // x0 never becomes pending nor written
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        tick();
        issue_valid = 1'b0;
        chk("x0_busy", busy, 32'h0000_0080);
        wb0_valid = 1'b1;
        wb0_rd    = 5'd0;
        wb0_data  = 32'h1;
        #1;
        chk("x0_ready0", {31'd0, wb0_ready}, 32'd1);
        tick();
        wb0_valid = 1'b0;
        chk("x0_wen", {31'd0, wen}, 32'd0);
        chk("x0_wnum", {27'd0, wnum}, 32'd0);

`ifdef WB_BYPASS_EN
        wb0_valid = 1'b1;
        wb0_rd    = 5'd3;
        wb0_data  = 32'h55;
        tick();
        wb0_valid = 1'b0;
        rnum1     = 5'd3;
        rd1_in    = 32'h0;
        rnum2     = 5'd0;
        rd2_in    = 32'hABCD;
        #1;
        chk("byp_rd1", rd1_out, 32'h55);
        chk("byp_rd2", rd2_out, 32'hABCD);
        tick();
        chk("byp_rd1_idle", rd1_out, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
